// File: rtl/prog_counter_pkg.sv
// Purpose: shared encodings for the programmable event counter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: mode_e (counter operating mode), DIR_UP/DIR_DOWN direction constants.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_SATURATE = 2'd0,
    MODE_WRAP     = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_RSVD     = 2'd3   // decoded as SATURATE
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/prog_counter_if.sv
// Purpose: control/status bundle between a counter user (master) and prog_counter (slave).
// Latency: n/a (wires only).
// Backpressure: none; controls are sampled every clock, status is always valid.
// Signals: clear/load/start/en strobes, load_value, limit, dir, mode in;
//          count, reached, tc, busy out.
interface prog_counter_if #(
  parameter int WIDTH = 5
);
  import counter_pkg::*;

  logic             clear;
  logic             en;
  logic             start;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] limit;
  logic             dir;
  mode_e            mode;
  logic [WIDTH-1:0] count;
  logic             reached;
  logic             tc;
  logic             busy;

  modport master (
    output clear, en, start, load, load_value, limit, dir, mode,
    input  count, reached, tc, busy
  );

  modport slave (
    input  clear, en, start, load, load_value, limit, dir, mode,
    output count, reached, tc, busy
  );

endinterface

// File: rtl/prog_counter_tick_prescaler.sv
// Purpose: divides enabled cycles down to one count step every PRESCALE enabled cycles.
// Latency: tick is combinational from the registered phase; phase updates on the next edge.
// Backpressure: none; phase holds while en=0, clr forces phase 0.
// Ports: clk, reset (async, active-high), clr (sync phase clear), en (advance), tick (step now).
module tick_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  if (PRESCALE == 1) begin : g_bypass
    // Every enabled cycle is a step; the caller gates tick with its own enable.
    logic unused_in;
    assign unused_in = ^{clk, reset, clr, en};
    assign tick      = 1'b1;
  end else begin : g_div
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] phase_q;
    logic [CW-1:0] phase_d;

    always_comb begin
      phase_d = phase_q;
      if (clr) begin
        phase_d = '0;
      end else if (en) begin
        phase_d = (phase_q == LAST) ? '0 : phase_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) phase_q <= '0;
      else       phase_q <= phase_d;
    end

    assign tick = (phase_q == LAST);
  end

endmodule

// File: rtl/prog_counter.sv
// Purpose: programmable up/down event counter with saturate/wrap/one-shot modes and prescaler.
// Latency: count/reached/tc/busy are registered and reflect a control input on the next edge.
// Backpressure: none; clear > load > start > step priority resolves conflicting strobes.
// Ports: clk, reset (async, active-high), bus (prog_counter_if.slave: controls in, status out).
module prog_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 1
) (
  input  logic           clk,
  input  logic           reset,
  prog_counter_if.slave  bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             reached_q, reached_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] start_val;
  logic [WIDTH-1:0] nxt;
  logic             is_oneshot;
  logic             adv_en;
  logic             start_ok;
  logic             pre_clr;
  logic             tick;
  logic             term_q;

  // Up-count is terminal at or above limit so a limit lowered below the
  // current count stops it at once; down-count is terminal only at zero.
  function automatic logic is_term(logic [WIDTH-1:0] c, logic [WIDTH-1:0] lim, logic d);
    return (d == DIR_DOWN) ? (c == '0) : (c >= lim);
  endfunction

  assign is_oneshot = (bus.mode == MODE_ONESHOT);
  assign start_val  = (bus.dir == DIR_UP) ? '0 : bus.limit;
  assign nxt        = (bus.dir == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
  assign term_q     = is_term(count_q, bus.limit, bus.dir);
  // In one-shot mode the prescaler only runs during an active run.
  assign adv_en     = bus.en && (!is_oneshot || busy_q);
  assign start_ok   = bus.start && is_oneshot && !busy_q;
  assign pre_clr    = bus.clear || bus.load || start_ok;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (pre_clr),
    .en    (adv_en),
    .tick  (tick)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    busy_d  = busy_q;

    if (bus.clear) begin
      count_d = start_val;
      busy_d  = 1'b0;
    end else if (bus.load) begin
      count_d = bus.load_value;
    end else if (start_ok) begin
      count_d = start_val;
      busy_d  = 1'b1;
    end else if (adv_en && tick) begin
      case (bus.mode)
        MODE_WRAP: begin
          if (term_q) begin
            count_d = start_val;
            tc_d    = 1'b1;
          end else begin
            count_d = nxt;
          end
        end
        MODE_ONESHOT: begin
          // A run started already at terminal finishes on its first step.
          if (term_q) begin
            busy_d = 1'b0;
            tc_d   = 1'b1;
          end else begin
            count_d = nxt;
            if (is_term(nxt, bus.limit, bus.dir)) begin
              busy_d = 1'b0;
              tc_d   = 1'b1;
            end
          end
        end
        default: begin
          if (!term_q) begin
            count_d = nxt;
            tc_d    = is_term(nxt, bus.limit, bus.dir);
          end
        end
      endcase
    end

    // Leaving one-shot mode abandons any run but keeps the count.
    if (!is_oneshot) busy_d = 1'b0;

    // Evaluated on the next count so reached lines up with count.
    reached_d = is_term(count_d, bus.limit, bus.dir);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= '0;
      reached_q <= 1'b0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      count_q   <= count_d;
      reached_q <= reached_d;
      tc_q      <= tc_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.reached = reached_q;
  assign bus.tc      = tc_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_prog_counter.sv
// Purpose: directed self-checking bench for prog_counter (PRESCALE=1 and PRESCALE=3 instances).
// Latency: expectations are queued before each edge and compared 1 time unit after it.
// Backpressure: n/a.
module tb_prog_counter;
  import counter_pkg::*;

  logic clk;
  logic reset;

  prog_counter_if #(.WIDTH(5)) if1 ();
  prog_counter_if #(.WIDTH(5)) if3 ();

  prog_counter #(.WIDTH(5), .PRESCALE(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  prog_counter #(.WIDTH(5), .PRESCALE(3)) dut3 (.clk(clk), .reset(reset), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    sel;
    int    cnt;
    bit    rch;
    bit    tcv;
    bit    bsy;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(string tag, int sel, int cnt, bit rch, bit tcv, bit bsy);
    exp_t e;
    e.tag = tag; e.sel = sel; e.cnt = cnt; e.rch = rch; e.tcv = tcv; e.bsy = bsy;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.sel == 1) begin
        cmp($sformatf("%s.count", e.tag),   32'(if1.count),   32'(e.cnt));
        cmp($sformatf("%s.reached", e.tag), 32'(if1.reached), 32'(e.rch));
        cmp($sformatf("%s.tc", e.tag),      32'(if1.tc),      32'(e.tcv));
        cmp($sformatf("%s.busy", e.tag),    32'(if1.busy),    32'(e.bsy));
      end else begin
        cmp($sformatf("%s.count", e.tag),   32'(if3.count),   32'(e.cnt));
        cmp($sformatf("%s.reached", e.tag), 32'(if3.reached), 32'(e.rch));
        cmp($sformatf("%s.tc", e.tag),      32'(if3.tc),      32'(e.tcv));
        cmp($sformatf("%s.busy", e.tag),    32'(if3.busy),    32'(e.bsy));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    if1.clear = 0; if1.en = 0; if1.start = 0; if1.load = 0; if1.load_value = '0;
    if1.limit = 5'd31; if1.dir = DIR_UP; if1.mode = MODE_SATURATE;
    if3.clear = 0; if3.en = 0; if3.start = 0; if3.load = 0; if3.load_value = '0;
    if3.limit = 5'd31; if3.dir = DIR_UP; if3.mode = MODE_SATURATE;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst1", 1, 0, 0, 0, 0);
    expect_out("rst3", 3, 0, 0, 0, 0);
    drain();
    reset = 1'b0;

    // Saturating up-count to 31
    if1.en = 1'b1;
    for (int i = 1; i <= 34; i++) begin
      expect_out($sformatf("sat_up[%0d]", i), 1, (i > 31) ? 31 : i, i >= 31, i == 31, 0);
      cycle();
    end

    // Wrap mode, limit 4: period 5
    if1.clear = 1'b1; if1.mode = MODE_WRAP; if1.limit = 5'd4;
    expect_out("wrap_clr", 1, 0, 0, 0, 0);
    cycle();
    if1.clear = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      expect_out($sformatf("wrap[%0d]", k), 1, k % 5, (k % 5) == 4, (k % 5) == 0, 0);
      cycle();
    end

    // Clear beats load in the same cycle; load alone next
    if1.en = 1'b0; if1.mode = MODE_SATURATE; if1.limit = 5'd31;
    if1.load = 1'b1; if1.load_value = 5'd20; if1.clear = 1'b1;
    expect_out("clr_over_load", 1, 0, 0, 0, 0);
    cycle();
    if1.clear = 1'b0;
    expect_out("load20", 1, 20, 0, 0, 0);
    cycle();
    if1.load = 1'b0;

    // Load zeroes the prescaler (PRESCALE=3)
    if3.en = 1'b1;
    expect_out("pre_a", 3, 0, 0, 0, 0);
    cycle();
    expect_out("pre_b", 3, 0, 0, 0, 0);
    cycle();
    if3.load = 1'b1; if3.load_value = 5'd20;
    expect_out("pre_load", 3, 20, 0, 0, 0);
    cycle();
    if3.load = 1'b0;
    expect_out("pre_d", 3, 20, 0, 0, 0);
    cycle();
    expect_out("pre_e", 3, 20, 0, 0, 0);
    cycle();
    expect_out("pre_step", 3, 21, 0, 0, 0);
    cycle();

    // Limit lowered below current count: terminal at once, count holds
    if1.en = 1'b1; if1.load = 1'b1; if1.load_value = 5'd10;
    expect_out("load10", 1, 10, 0, 0, 0);
    cycle();
    if1.load = 1'b0; if1.limit = 5'd5;
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("lim_drop[%0d]", i), 1, 10, 1, 0, 0);
      cycle();
    end

    // One-shot down-count from 6 with PRESCALE=3; re-start at cycle 5 ignored
    if3.en = 1'b0; if3.mode = MODE_ONESHOT; if3.dir = DIR_DOWN; if3.limit = 5'd6;
    if3.start = 1'b1;
    expect_out("os_start", 3, 6, 0, 0, 1);
    cycle();
    if3.start = 1'b0; if3.en = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      if3.start = (j == 5);
      expect_out($sformatf("os[%0d]", j), 3, 6 - j / 3, j == 18, j == 18, j < 18);
      cycle();
    end
    if3.start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      expect_out($sformatf("os_idle[%0d]", j), 3, 0, 1, 0, 0);
      cycle();
    end

    // Leaving one-shot mode drops busy, keeps count
    if3.en = 1'b0; if3.start = 1'b1;
    expect_out("os_restart", 3, 6, 0, 0, 1);
    cycle();
    if3.start = 1'b0; if3.mode = MODE_SATURATE;
    expect_out("os_abandon", 3, 6, 0, 0, 0);
    cycle();

    // Asynchronous reset in the middle of a wrap count
    if1.mode = MODE_WRAP; if1.limit = 5'd4; if1.dir = DIR_UP; if1.clear = 1'b1; if1.en = 1'b1;
    expect_out("ar_clr", 1, 0, 0, 0, 0);
    cycle();
    if1.clear = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      expect_out($sformatf("ar_pre[%0d]", k), 1, k, 0, 0, 0);
      cycle();
    end
    #3;
    reset = 1'b1;
    #1;
    expect_out("ar_async", 1, 0, 0, 0, 0);
    drain();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      expect_out($sformatf("ar_post[%0d]", k), 1, k % 5, (k % 5) == 4, (k % 5) == 0, 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
